// File: rtl/ray_hit_accumulator.sv
// Folds the per-batch hit results of one ray into a single final hit and hands
// it to shading over valid/ready; any-hit rays request early traversal stop.
module ray_hit_accumulator #(
  parameter  int RAY_ID_WIDTH    = 8,
  parameter  int BATCH_CNT_WIDTH = 16,
  localparam int HIT_WIDTH       = 125
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [RAY_ID_WIDTH-1:0]    start_ray_id,
  input  logic                       any_hit_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [HIT_WIDTH-1:0]       in_hit,
  input  logic                       in_last,
  output logic                       early_term,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [HIT_WIDTH-1:0]       out_hit,
  output logic [RAY_ID_WIDTH-1:0]    out_ray_id,
  output logic [BATCH_CNT_WIDTH-1:0] out_batches
);

  // T is signed Q16.16; the largest positive value stands in for infinity.
  typedef logic signed [31:0] fixed_t;

  typedef struct packed {
    logic        bHit;
    fixed_t      T;
    logic [15:0] PI;
    logic [3:0]  SurfaceType;
    logic [23:0] Color;
    logic [15:0] normalX;
    logic [15:0] normalY;
    logic [15:0] normalZ;
  } hit_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    RESULT
  } state_t;

  localparam fixed_t FIXED_INF = 32'sh7FFF_FFFF;
  localparam hit_t   MISS_HIT  = hit_t'({1'b0, FIXED_INF, 92'd0});

  state_t                     state_q, state_d;
  hit_t                       best_q, best_d;
  logic [BATCH_CNT_WIDTH-1:0] count_q, count_d;
  logic [RAY_ID_WIDTH-1:0]    rayId_q, rayId_d;
  logic                       anyHit_q, anyHit_d;
  logic                       inReady_q, earlyTerm_q, busy_q, outValid_q;

  hit_t                       inHit;
  logic                       accept;
  logic                       closer;
  logic [BATCH_CNT_WIDTH-1:0] countInc;

  assign inHit    = hit_t'(in_hit);
  assign accept   = in_valid && inReady_q;
  assign countInc = (count_q == '1) ? count_q : count_q + 1'b1;
  // Strict compare: a later hit at exactly the same distance does not win.
  assign closer   = inHit.bHit && (!best_q.bHit || ($signed(best_q.T) > $signed(inHit.T)));

  always_comb begin
    state_d  = state_q;
    best_d   = best_q;
    count_d  = count_q;
    rayId_d  = rayId_q;
    anyHit_d = anyHit_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          best_d   = MISS_HIT;
          count_d  = '0;
          rayId_d  = start_ray_id;
          anyHit_d = any_hit_mode;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          count_d = countInc;
          if (anyHit_q) begin
            if (inHit.bHit) begin
              best_d  = inHit;
              state_d = in_last ? RESULT : DRAIN;
            end else if (in_last) begin
              state_d = RESULT;
            end
          end else begin
            if (closer) begin
              best_d = inHit;
            end
            if (in_last) begin
              state_d = RESULT;
            end
          end
        end
      end
      DRAIN: begin
        if (accept) begin
          count_d = countInc;
          if (in_last) begin
            state_d = RESULT;
          end
        end
      end
      RESULT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs are registered from the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      best_q      <= MISS_HIT;
      count_q     <= '0;
      rayId_q     <= '0;
      anyHit_q    <= 1'b0;
      inReady_q   <= 1'b0;
      earlyTerm_q <= 1'b0;
      busy_q      <= 1'b0;
      outValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      best_q      <= best_d;
      count_q     <= count_d;
      rayId_q     <= rayId_d;
      anyHit_q    <= anyHit_d;
      inReady_q   <= (state_d == ACCUM) || (state_d == DRAIN);
      earlyTerm_q <= (state_d == DRAIN);
      busy_q      <= (state_d != IDLE);
      outValid_q  <= (state_d == RESULT);
    end
  end

  assign in_ready    = inReady_q;
  assign early_term  = earlyTerm_q;
  assign busy        = busy_q;
  assign out_valid   = outValid_q;
  assign out_hit     = best_q;
  assign out_ray_id  = rayId_q;
  assign out_batches = count_q;

endmodule

// File: tb/tb_ray_hit_accumulator.sv
// Directed bench for ray_hit_accumulator: closest, tie, miss, any-hit,
// backpressure and mid-ray reset scenarios with hand-computed expectations.
module tb_ray_hit_accumulator;

  localparam int HW = 125;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [7:0]    start_ray_id;
  logic          any_hit_mode;
  logic          in_valid;
  logic          in_ready;
  logic [HW-1:0] in_hit;
  logic          in_last;
  logic          early_term;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [HW-1:0] out_hit;
  logic [7:0]    out_ray_id;
  logic [15:0]   out_batches;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  localparam logic [HW-1:0] MISS = {1'b0, 32'h7FFF_FFFF, 92'd0};

  ray_hit_accumulator dut (
    .clk(clk), .resetn(resetn), .start(start), .start_ray_id(start_ray_id),
    .any_hit_mode(any_hit_mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_hit(in_hit), .in_last(in_last), .early_term(early_term), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
    .out_ray_id(out_ray_id), .out_batches(out_batches)
  );

  always #5 clk = ~clk;

  // Field order: bHit, T(Q16.16), PI, SurfaceType, Color, normal x/y/z.
  function automatic logic [HW-1:0] mkHit(input logic b, input logic [31:0] t, input logic [15:0] pi);
    return {b, t, pi, pi[3:0], {8'hC0, pi}, {pi, ~pi, pi ^ 16'h5A5A}};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic b, input logic [31:0] t, input logic [15:0] pi, input logic last);
    in_valid = 1'b1;
    in_hit   = mkHit(b, t, pi);
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic startRay(input logic [7:0] id, input logic mode);
    start        = 1'b1;
    start_ray_id = id;
    any_hit_mode = mode;
    step();
    start        = 1'b0;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_in_ready"},   in_ready,    0);
    checkOutput({tag, "_early_term"}, early_term,  0);
    checkOutput({tag, "_busy"},       busy,        0);
    checkOutput({tag, "_out_valid"},  out_valid,   0);
    checkOutput({tag, "_out_hit"},    out_hit,     MISS);
    checkOutput({tag, "_ray_id"},     out_ray_id,  0);
    checkOutput({tag, "_batches"},    out_batches, 0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; start_ray_id = '0; any_hit_mode = 1'b0;
    in_valid = 1'b0; in_hit = '0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    checkResetValues("reset");
    #10 resetn = 1'b1;
    step();

    // Closest-hit ray: nearest hit is T=1.5
    startRay(8'd5, 1'b0);
    checkOutput("c_busy", busy, 1);
    checkOutput("c_in_ready", in_ready, 1);
    applyStimulus(1'b1, 32'h0003_0000, 16'd1, 1'b0);
    applyStimulus(1'b1, 32'h0001_8000, 16'd2, 1'b0);
    applyStimulus(1'b0, 32'h0000_8000, 16'd3, 1'b0);
    checkOutput("c_no_valid_yet", out_valid, 0);
    applyStimulus(1'b1, 32'h0002_0000, 16'd4, 1'b1);
    checkOutput("c_out_valid", out_valid, 1);
    checkOutput("c_in_ready_res", in_ready, 0);
    checkOutput("c_out_hit", out_hit, mkHit(1'b1, 32'h0001_8000, 16'd2));
    checkOutput("c_ray_id", out_ray_id, 5);
    checkOutput("c_batches", out_batches, 4);
    releaseResult();
    checkOutput("c_valid_drop", out_valid, 0);
    checkOutput("c_idle", busy, 0);

    // Equal T keeps the earlier hit
    startRay(8'd6, 1'b0);
    applyStimulus(1'b1, 32'h0001_8000, 16'd7, 1'b0);
    applyStimulus(1'b1, 32'h0001_8000, 16'd9, 1'b1);
    checkOutput("tie_out_hit", out_hit, mkHit(1'b1, 32'h0001_8000, 16'd7));
    checkOutput("tie_batches", out_batches, 2);
    releaseResult();

    // Negative T must win over positive (signed compare)
    startRay(8'd7, 1'b0);
    applyStimulus(1'b1, 32'h0001_0000, 16'd20, 1'b0);
    applyStimulus(1'b1, 32'hFFFE_0000, 16'd21, 1'b1);
    checkOutput("neg_out_hit", out_hit, mkHit(1'b1, 32'hFFFE_0000, 16'd21));
    releaseResult();

    // All misses, including one with a tiny T
    startRay(8'd8, 1'b0);
    applyStimulus(1'b0, 32'h0001_0000, 16'd30, 1'b0);
    applyStimulus(1'b0, 32'h0000_0001, 16'd31, 1'b0);
    applyStimulus(1'b0, 32'h0000_4000, 16'd32, 1'b1);
    checkOutput("miss_out_valid", out_valid, 1);
    checkOutput("miss_out_hit", out_hit, MISS);
    checkOutput("miss_batches", out_batches, 3);
    releaseResult();

    // Any-hit ray: first hit freezes the result and raises early_term
    startRay(8'd9, 1'b1);
    applyStimulus(1'b0, 32'h0001_0000, 16'd40, 1'b0);
    checkOutput("ah_no_term", early_term, 0);
    applyStimulus(1'b1, 32'h0004_0000, 16'd41, 1'b0);
    checkOutput("ah_early_term", early_term, 1);
    checkOutput("ah_drain_ready", in_ready, 1);
    applyStimulus(1'b1, 32'h0000_8000, 16'd42, 1'b0);
    applyStimulus(1'b0, 32'h0002_0000, 16'd43, 1'b1);
    checkOutput("ah_out_valid", out_valid, 1);
    checkOutput("ah_out_hit", out_hit, mkHit(1'b1, 32'h0004_0000, 16'd41));
    checkOutput("ah_batches", out_batches, 4);
    checkOutput("ah_term_off", early_term, 0);
    checkOutput("ah_ray_id", out_ray_id, 9);

    // Backpressure in RESULT with stray start and in_valid
    in_valid     = 1'b1;
    in_hit       = mkHit(1'b1, 32'h0000_0100, 16'd99);
    in_last      = 1'b1;
    start        = 1'b1;
    start_ray_id = 8'd77;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("bp_valid", out_valid, 1);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_out_hit", out_hit, mkHit(1'b1, 32'h0004_0000, 16'd41));
      checkOutput("bp_ray_id", out_ray_id, 9);
      checkOutput("bp_batches", out_batches, 4);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    releaseResult();
    checkOutput("bp_idle_busy", busy, 0);
    checkOutput("bp_idle_valid", out_valid, 0);

    // Mid-ray reset discards the ray
    startRay(8'd3, 1'b0);
    applyStimulus(1'b1, 32'h0001_0000, 16'd50, 1'b0);
    applyStimulus(1'b1, 32'h0000_8000, 16'd51, 1'b0);
    resetn = 1'b0;
    #1;
    checkResetValues("midrst");
    #3 resetn = 1'b1;
    step();
    checkOutput("midrst_stays_idle", out_valid, 0);
    startRay(8'd4, 1'b0);
    applyStimulus(1'b1, 32'h0002_0000, 16'd11, 1'b1);
    checkOutput("post_out_valid", out_valid, 1);
    checkOutput("post_out_hit", out_hit, mkHit(1'b1, 32'h0002_0000, 16'd11));
    checkOutput("post_ray_id", out_ray_id, 4);
    checkOutput("post_batches", out_batches, 1);
    releaseResult();
    checkOutput("post_idle", busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
